mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory port between the IF stage (instruction fetch) and the EX/MEM stage (load/store).
- Allows one outstanding transaction at a time; data has fixed priority over instruction.
- Returns read data and a completion strobe to each requester.
- Drives a stall request into the pipeline stall controller while any accepted request is still outstanding.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 255, maximum cycles waiting for mem_rvalid before a forced error completion; width of the wait counter is clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held by IF until inst_ok.
- inst_addr  in  ADDR_W  fetch address, stable while inst_req.
- inst_rdata  out  DATA_W  fetch data, valid only when inst_ok.
- inst_ok  out  1  fetch completion, one-cycle strobe.
- data_req  in  1  load/store request; held until data_ok.
- data_wen  in  DATA_W/8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load data, valid only when data_ok.
- data_ok  out  1  load/store completion, one-cycle strobe.
- mem_req  out  1  memory request.
- mem_wen  out  DATA_W/8  byte enables to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  response for the accepted transaction; returned for writes as well.
- mem_rdata  in  DATA_W  response data.
- bus_err  out  1  one-cycle strobe on a timeout completion.
- stallreq_for_mem  out  1  stall request to the stall controller.

Behaviour:
- FSM states:
  - IDLE: no transaction in flight.
  - ISSUE: request on the bus, waiting for mem_gnt.
  - WAIT: accepted, waiting for mem_rvalid.
- Owner register: INST or DATA.
- Reset (rst=1 at edge): state=IDLE, owner=INST, wait counter=0.
- Outputs during reset and in IDLE:
  - mem_req=0, mem_wen=0.
  - inst_ok=0, data_ok=0, bus_err=0.
  - inst_rdata=0, data_rdata=0.
  - mem_addr and mem_wdata are 0.
- IDLE:
  - If data_req, then owner<=DATA and go to ISSUE; else if inst_req, then owner<=INST and go to ISSUE.
  - When both are requested in the same cycle, data wins; inst stays pending.
- ISSUE:
  - mem_req=1; mem_addr, mem_wen and mem_wdata are combinationally muxed from the owner's inputs. For owner INST, mem_wen=0 and mem_wdata=0.
  - On mem_gnt, go to WAIT and clear the counter.
  - mem_gnt seen while mem_req=0 is ignored.
- WAIT:
  - mem_req=0; the counter increments each cycle.
  - On mem_rvalid:
    - The owner's ok=1 in that same cycle, combinationally.
    - The owner's rdata = mem_rdata, combinationally.
    - Next state is IDLE.
  - If mem_rvalid and the timeout happen in the same cycle, mem_rvalid wins.
  - If the counter reaches TIMEOUT_CYC without mem_rvalid:
    - The owner's ok=1 and rdata=0.
    - bus_err=1 for that cycle.
    - Next state is IDLE.
- Latency:
  - Best case, request to ok is 2 cycles after the IDLE cycle (mem_gnt in the first ISSUE cycle, mem_rvalid in the first WAIT cycle).
  - The IDLE-to-ISSUE transition always costs 1 cycle.
  - The cycle after any ok is always IDLE, so a requester holding the same req is never re-issued in the ok cycle.
- Back-to-back arbitration:
  - After a DATA completion with inst_req pending, IDLE grants INST unless data_req is high again.
  - Starvation of inst is bounded by the pipeline, since data_req is dropped while EX is stalled.
- stallreq_for_mem = (inst_req & ~inst_ok) | (data_req & ~data_ok), combinational. It is 0 during reset.
- Requester inputs changing mid-transaction:
  - Only the owner's inputs as sampled in ISSUE are used.
  - If the owner's req drops during WAIT, the response is still consumed and its ok still pulses.
- Reset mid-operation: the transaction is abandoned and the FSM returns to IDLE. A stray mem_rvalid in IDLE or ISSUE is ignored; the memory model is reset alongside.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- With the macro defined, three 32-bit saturating output counters are added:
  - perf_inst_cnt: increments on each inst completion.
  - perf_data_cnt: increments on each data completion.
  - perf_stall_cnt: increments on each cycle with stallreq_for_mem=1.
- All three counters are cleared by rst and hold at 32'hFFFFFFFF.
- Without the macro: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single fetch:
  - Stimulus: inst_req=1, inst_addr=32'hBFC00000; mem grants at once; rvalid with 32'h3C08BFAF one cycle later.
  - Required: mem_addr=BFC00000, mem_wen=0; inst_ok one cycle with inst_rdata=3C08BFAF; stallreq high for exactly 2 cycles, then 0.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (addr 32'h00001000, read) both rise in the same cycle.
  - Required: data is issued first; inst is issued only in the first ISSUE after the data completion; stallreq held continuously until inst_ok.
- Store:
  - Stimulus: data_req, data_wen=4'b0011, data_wdata=32'h0000ABCD; mem_gnt delayed 3 cycles.
  - Required: mem_req high for 4 cycles with wen=0011; data_ok only on mem_rvalid.
- Timeout:
  - Stimulus: TIMEOUT_CYC=8; mem grants but never asserts rvalid.
  - Required: data_ok=1, bus_err=1, data_rdata=0 on the 8th WAIT cycle; next cycle IDLE.
- Reset mid-op:
  - Stimulus: rst=1 in WAIT, then a late mem_rvalid.
  - Required: outputs zero after the reset edge; no ok pulse; next request proceeds normally.
- MEM_ARB_PERF_EN:
  - Stimulus: 3 fetches and 2 loads.
  - Required: perf_inst_cnt=3, perf_data_cnt=2; perf_stall_cnt equals the cycles with stallreq_for_mem=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: data has priority, one transaction in flight.
// Define MEM_ARB_PERF_EN to add saturating completion/stall counters.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inst_req,
  input  logic [ADDR_W-1:0]   i_inst_addr,
  output logic [DATA_W-1:0]   o_inst_rdata,
  output logic                o_inst_ok,
  input  logic                i_data_req,
  input  logic [DATA_W/8-1:0] i_data_wen,
  input  logic [ADDR_W-1:0]   i_data_addr,
  input  logic [DATA_W-1:0]   i_data_wdata,
  output logic [DATA_W-1:0]   o_data_rdata,
  output logic                o_data_ok,
  output logic                o_mem_req,
  output logic [DATA_W/8-1:0] o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_bus_err,
  output logic                o_stallreq_for_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         o_perf_inst_cnt,
  output logic [31:0]         o_perf_data_cnt,
  output logic [31:0]         o_perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]       r_state;
  logic             r_owner;
  logic [CNT_W-1:0] r_wait_cnt;

  logic             w_issue;
  logic             w_wait;
  logic             w_timeout_hit;
  logic             w_timeout;
  logic             w_done;
  logic             w_inst_ok;
  logic             w_data_ok;
  logic [DATA_W-1:0] w_rsp_data;

  // Every status output is gated by rst so the pipeline sees a quiet port during reset.
  assign w_issue       = ~rst & (r_state == S_ISSUE);
  assign w_wait        = ~rst & (r_state == S_WAIT);
  assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_timeout     = w_wait & ~i_mem_rvalid & w_timeout_hit;
  assign w_done        = w_wait & (i_mem_rvalid | w_timeout_hit);
  assign w_inst_ok     = w_done & (r_owner == OWN_INST);
  assign w_data_ok     = w_done & (r_owner == OWN_DATA);
  assign w_rsp_data    = i_mem_rvalid ? i_mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_INST;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_data_req) begin
            r_owner <= OWN_DATA;
            r_state <= S_ISSUE;
          end else if (i_inst_req) begin
            r_owner <= OWN_INST;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_gnt) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          if (i_mem_rvalid || w_timeout_hit) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_req   = w_issue;
    o_mem_wen   = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_issue) begin
      if (r_owner == OWN_DATA) begin
        o_mem_addr  = i_data_addr;
        o_mem_wen   = i_data_wen;
        o_mem_wdata = i_data_wdata;
      end else begin
        o_mem_addr  = i_inst_addr;
      end
    end
  end

  assign o_inst_ok    = w_inst_ok;
  assign o_data_ok    = w_data_ok;
  assign o_inst_rdata = w_inst_ok ? w_rsp_data : '0;
  assign o_data_rdata = w_data_ok ? w_rsp_data : '0;
  assign o_bus_err    = w_timeout;

  assign o_stallreq_for_mem = ~rst & ((i_inst_req & ~w_inst_ok) | (i_data_req & ~w_data_ok));

`ifdef MEM_ARB_PERF_EN
  logic [2:0] w_perf_inc;
  assign w_perf_inc = {o_stallreq_for_mem, w_data_ok, w_inst_ok};

  // Index 0: fetch completions, 1: data completions, 2: stall cycles; all saturate.
  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_perf_inc[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_perf_inst_cnt  = g_perf[0].r_cnt;
  assign o_perf_data_cnt  = g_perf[1].r_cnt;
  assign o_perf_stall_cnt = g_perf[2].r_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases with a hand-driven memory, then random traffic
// against a behavioural memory; completions are checked by a negedge monitor popping expected queues.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, data_req;
  logic [AW-1:0] inst_addr, data_addr;
  logic [BW-1:0] data_wen;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          inst_ok, data_ok;
  logic          mem_req, mem_gnt, mem_rvalid;
  logic [BW-1:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          bus_err, stallreq;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_inst_cnt, perf_data_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr),
    .o_inst_rdata(inst_rdata), .o_inst_ok(inst_ok),
    .i_data_req(data_req), .i_data_wen(data_wen), .i_data_addr(data_addr),
    .i_data_wdata(data_wdata), .o_data_rdata(data_rdata), .o_data_ok(data_ok),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata), .o_bus_err(bus_err), .o_stallreq_for_mem(stallreq)
`ifdef MEM_ARB_PERF_EN
    , .o_perf_inst_cnt(perf_inst_cnt), .o_perf_data_cnt(perf_data_cnt),
    .o_perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t inst_exp[$];
  exp_t data_exp[$];
  exp_t mon_e;
  bit   mem_auto = 1'b0;
  int   n_inst_done = 0, n_data_done = 0, n_stall_cyc = 0;
  logic [DW-1:0] mem_arr[logic [AW-1:0]];
  logic [DW-1:0] ref_arr[logic [AW-1:0]];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Power-on contents of every memory word.
  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
  endfunction

  function automatic exp_t mk_exp(logic [DW-1:0] d, logic e);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    return x;
  endfunction

  // Behavioural memory: random grant/response delay; addresses with bit 30 set never answer.
  task automatic mem_serve();
    logic [AW-1:0] a;
    logic [BW-1:0] w;
    logic [DW-1:0] wd, word;
    repeat ($urandom_range(0, 3)) step();
    a = mem_addr; w = mem_wen; wd = mem_wdata;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    word = mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    for (int b = 0; b < BW; b++) if (w[b]) word[8*b +: 8] = wd[8*b +: 8];
    mem_arr[a] = word;
    if (a[30]) return;
    repeat ($urandom_range(0, 3)) step();
    mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    forever begin
      step();
      if (mem_auto && !rst && mem_req) mem_serve();
    end
  end

  task automatic if_proc(int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      bit done;
      repeat ($urandom_range(0, 2)) step();
      a = 32'h8000_0000 | AW'($urandom_range(0, 15) << 2);
      inst_exp.push_back(mk_exp(init_word(a), 1'b0));
      inst_addr = a; inst_req = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (inst_ok) done = 1'b1;
      end
      chk("if_wait_ok", {31'b0, done}, 32'd1);
      step();
      inst_req = 1'b0;
    end
  endtask

  task automatic ex_proc(int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [BW-1:0] w;
      logic [DW-1:0] wd, cur;
      int kind, idx;
      bit done;
      repeat ($urandom_range(0, 2)) step();
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 7);
      wd   = $urandom;
      if (kind == 0) begin
        a = 32'h4000_0000 | AW'(idx * 4); w = '0;
        data_exp.push_back(mk_exp('0, 1'b1));
      end else begin
        a = 32'h0000_1000 + AW'(idx * 4);
        w = (kind < 5) ? '0 : BW'($urandom_range(1, 15));
        cur = ref_rd(a);
        for (int b = 0; b < BW; b++) if (w[b]) cur[8*b +: 8] = wd[8*b +: 8];
        if (w != 0) ref_arr[a] = cur;
        data_exp.push_back(mk_exp(cur, 1'b0));
      end
      data_addr = a; data_wen = w; data_wdata = wd; data_req = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        if (data_ok) done = 1'b1;
      end
      chk("ex_wait_ok", {31'b0, done}, 32'd1);
      step();
      data_req = 1'b0; data_wen = '0;
    end
  endtask

  // Completion scoreboard and bus-accept check.
  always @(negedge clk) begin
    if (rst) begin
      n_inst_done = 0; n_data_done = 0; n_stall_cyc = 0;
    end else begin
      if (stallreq) n_stall_cyc++;
      if (inst_ok) begin
        n_inst_done++;
        if (inst_exp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL inst_ok_unexpected: got inst_ok=1 rdata=%h expected no pending fetch", inst_rdata);
        end else begin
          mon_e = inst_exp.pop_front();
          chk("inst_rdata", inst_rdata, mon_e.rdata);
          chk("inst_bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
        end
      end else begin
        chk("inst_rdata_idle", inst_rdata, '0);
      end
      if (data_ok) begin
        n_data_done++;
        if (data_exp.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL data_ok_unexpected: got data_ok=1 rdata=%h expected no pending access", data_rdata);
        end else begin
          mon_e = data_exp.pop_front();
          chk("data_rdata", data_rdata, mon_e.rdata);
          chk("data_bus_err", {31'b0, bus_err}, {31'b0, mon_e.err});
        end
      end else begin
        chk("data_rdata_idle", data_rdata, '0);
      end
      chk("bus_err_orphan", {31'b0, bus_err & ~inst_ok & ~data_ok}, 32'd0);
      if (mem_req && mem_gnt) begin
        n_tests++;
        if (!((data_req && mem_addr === data_addr && mem_wen === data_wen && mem_wdata === data_wdata) ||
              (inst_req && mem_addr === inst_addr && mem_wen === '0 && mem_wdata === '0))) begin
          n_fail++;
          $display("FAIL bus_accept: got addr=%h wen=%h wdata=%h expected a pending requester's fields",
                   mem_addr, mem_wen, mem_wdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    inst_addr = 32'h8000_0000; data_addr = 32'h1000; data_wen = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    // Reset: every output quiet even with both requests high.
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stallreq}, 32'd0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_ok", {30'b0, inst_ok, data_ok}, 32'd0);
    inst_req = 1'b0; data_req = 1'b0;
    step(); rst = 1'b0;
    step();

    // Single fetch, best-case latency.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    inst_exp.push_back(mk_exp(32'h3C08_BFAF, 1'b0));
    #1 chk("f1_idle_stall", {31'b0, stallreq}, 32'd1);
    chk("f1_idle_req", {31'b0, mem_req}, 32'd0);
    step(); mem_gnt = 1'b1;
    #1 chk("f1_req", {31'b0, mem_req}, 32'd1);
    chk("f1_addr", mem_addr, 32'hBFC0_0000);
    chk("f1_wen", {28'b0, mem_wen}, 32'd0);
    chk("f1_stall", {31'b0, stallreq}, 32'd1);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h3C08_BFAF;
    #1 chk("f1_ok", {31'b0, inst_ok}, 32'd1);
    chk("f1_stall_ok", {31'b0, stallreq}, 32'd0);
    step(); mem_rvalid = 1'b0; mem_rdata = '0; inst_req = 1'b0;
    #1 chk("f1_after_stall", {31'b0, stallreq}, 32'd0);
    chk("f1_after_req", {31'b0, mem_req}, 32'd0);

    // Simultaneous requests: data first, then inst, stall held throughout.
    step();
    inst_req = 1'b1; inst_addr = 32'h8000_0010;
    data_req = 1'b1; data_addr = 32'h0000_1000; data_wen = '0;
    data_exp.push_back(mk_exp(32'hD00D_0001, 1'b0));
    inst_exp.push_back(mk_exp(32'h1A5A_0002, 1'b0));
    #1 chk("sim_stall0", {31'b0, stallreq}, 32'd1);
    step(); mem_gnt = 1'b1;
    #1 chk("sim_first_addr", mem_addr, 32'h0000_1000);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hD00D_0001;
    #1 chk("sim_data_ok", {31'b0, data_ok}, 32'd1);
    chk("sim_stall1", {31'b0, stallreq}, 32'd1);
    step(); mem_rvalid = 1'b0; mem_rdata = '0; data_req = 1'b0;
    #1 chk("sim_idle_req", {31'b0, mem_req}, 32'd0);
    chk("sim_stall2", {31'b0, stallreq}, 32'd1);
    step(); mem_gnt = 1'b1;
    #1 chk("sim_second_addr", mem_addr, 32'h8000_0010);
    chk("sim_stall3", {31'b0, stallreq}, 32'd1);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1A5A_0002;
    #1 chk("sim_inst_ok", {31'b0, inst_ok}, 32'd1);
    step(); mem_rvalid = 1'b0; mem_rdata = '0; inst_req = 1'b0;

    // Store with grant delayed three cycles.
    step();
    data_req = 1'b1; data_addr = 32'h0000_1004; data_wen = 4'b0011; data_wdata = 32'h0000_ABCD;
    data_exp.push_back(mk_exp(32'h0000_ABCD, 1'b0));
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) mem_gnt = 1'b1;
      #1 chk("st_req", {31'b0, mem_req}, 32'd1);
      chk("st_wen", {28'b0, mem_wen}, 32'd3);
      chk("st_wdata", mem_wdata, 32'h0000_ABCD);
    end
    step(); mem_gnt = 1'b0;
    #1 chk("st_wait_no_ok", {31'b0, data_ok}, 32'd0);
    chk("st_wait_req", {31'b0, mem_req}, 32'd0);
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_ABCD;
    #1 chk("st_ok", {31'b0, data_ok}, 32'd1);
    step(); mem_rvalid = 1'b0; mem_rdata = '0; data_req = 1'b0; data_wen = '0;

    // Timeout, then rvalid colliding with the timeout cycle.
    for (int t = 0; t < 2; t++) begin
      step();
      data_req = 1'b1; data_addr = 32'h0000_1008; data_wen = '0;
      data_exp.push_back(t == 0 ? mk_exp('0, 1'b1) : mk_exp(32'h1234_5678, 1'b0));
      step(); mem_gnt = 1'b1;
      step(); mem_gnt = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      for (int k = 1; k <= TO; k++) begin
        if (k == TO && t == 1) begin mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; end
        #1;
        if (k < TO) begin
          chk("to_early_ok", {31'b0, data_ok}, 32'd0);
        end else begin
          chk("to_ok", {31'b0, data_ok}, 32'd1);
          chk("to_err", {31'b0, bus_err}, (t == 0) ? 32'd1 : 32'd0);
        end
        step();
      end
      data_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #1 chk("to_next_idle", {31'b0, mem_req | data_ok | bus_err}, 32'd0);
    end

    // Reset in WAIT with a response arriving during and after reset.
    step();
    inst_req = 1'b1; inst_addr = 32'h8000_0020;
    step(); mem_gnt = 1'b1;
    step(); mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1 chk("rm_ok", {30'b0, inst_ok, data_ok}, 32'd0);
    chk("rm_rdata", inst_rdata, '0);
    chk("rm_stall", {31'b0, stallreq}, 32'd0);
    step(); rst = 1'b0; inst_req = 1'b0;
    #1 chk("rm_stray_ok", {30'b0, inst_ok, data_ok}, 32'd0);
    chk("rm_stray_req", {31'b0, mem_req}, 32'd0);
    step(); mem_rvalid = 1'b0; mem_rdata = '0;
    inst_req = 1'b1; inst_addr = 32'h8000_0024;
    inst_exp.push_back(mk_exp(32'h0BAD_F00D, 1'b0));
    step(); mem_gnt = 1'b1;
    #1 chk("rm_next_addr", mem_addr, 32'h8000_0024);
    step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1 chk("rm_next_ok", {31'b0, inst_ok}, 32'd1);
    step(); mem_rvalid = 1'b0; mem_rdata = '0; inst_req = 1'b0;

    // Random concurrent traffic against the behavioural memory.
    step();
    mem_auto = 1'b1;
    fork
      if_proc(40);
      ex_proc(40);
    join
    repeat (4) step();
    mem_auto = 1'b0;
    repeat (4) step();
    chk("inst_q_empty", inst_exp.size(), 32'd0);
    chk("data_q_empty", data_exp.size(), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("perf_inst", perf_inst_cnt, n_inst_done);
    chk("perf_data", perf_data_cnt, n_data_done);
    chk("perf_stall", perf_stall_cnt, n_stall_cyc);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
